bin_to_digits: RTL
==================

// Module: bin_to_digits
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3) that feeds the 4-digit seven-segment multiplexer.
//  Accepts an unsigned IN_W-bit value on a start strobe and produces the packed 20-bit big_bin word:
//  four 5-bit display codes, digit0 = ones = big_bin[4:0], digit3 = thousands = big_bin[19:15].
//  Optional leading-zero blanking. Values > 9999 display as four dashes.
//  big_bin is registered and holds its value between conversions, so the display never glitches.
// PARAMETERS
//  IN_W        14     width of bin_in; 14 covers 0..16383
//  DIG_W       5      bits per display code in big_bin
//  BLANK_CODE  5'd16  code the decoder renders as all segments off
//  DASH_CODE   5'd17  code the decoder renders as segment g only
// PORTS
//  clk      in   1       system clock; the only clock
//  rst      in   1       synchronous, active-high reset
//  bin_in   in   IN_W    unsigned value to convert; sampled only when start is accepted
//  start    in   1       request strobe; level-sampled at each posedge
//  blank_en in   1       1 = suppress leading zeros; sampled with bin_in
//  busy     out  1       conversion in progress
//  done     out  1       one-cycle pulse: big_bin has just been updated
//  big_bin  out  20      {d3,d2,d1,d0}, each DIG_W bits; d = 0..9, BLANK_CODE or DASH_CODE
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, busy=0, done=0, shift/BCD regs=0,
//   big_bin={BLANK,BLANK,BLANK,0}=20'h84200. rst wins over start.
//  FSM states:
//   IDLE  - if start: capture bin_in and blank_en, BCD acc=0, bit counter=IN_W-1,
//           ovf=(bin_in>9999), busy<=1, go to SHIFT. Otherwise hold.
//   SHIFT - each cycle: every BCD nibble >=5 gets +3, then {bcd,shreg}<<=1.
//           Counter decrements; after IN_W SHIFT cycles, go to PACK.
//   PACK  - build digits from the 16-bit BCD acc. If ovf, all four = DASH_CODE.
//           Else if latched blank_en, each leading zero from d3 down to d1 = BLANK_CODE;
//           d0 is never blanked.
//           Zero-extend each nibble to DIG_W. big_bin<=result, done<=1, busy<=0, go to IDLE.
//  Latency: start accepted at edge E0 -> busy=1 after E0; SHIFT on E1..E_IN_W;
//   PACK on E_(IN_W+1); done=1 for exactly the cycle after E_(IN_W+1). That is 15 cycles at IN_W=14.
//  Conversion time is constant and independent of value or overflow.
//  start while busy=1: ignored, not queued. bin_in may change freely after acceptance.
//  start high in the done cycle (state IDLE): accepted; back-to-back period = IN_W+2 cycles.
//  start held high continuously: conversions repeat back-to-back.
//  Reset mid-conversion: abort immediately, with the reset values above; no done pulse.
//  Width rules: BCD acc 16 bits; add-3 is applied per nibble before the shift in the same cycle.
//   The overflow path ignores BCD carry-out beyond 16 bits.
//  done and busy are never high together.
// STRUCTURE
//  Shared include seg_codes.vh: BLANK_CODE, DASH_CODE, DIG_W, MAX_DISPLAY=9999.
//   The same file is used by binary_to_segment so the codes stay consistent.
//  Sub-module bcd_add3: 4-bit combinational cell, out = (in>=5) ? in+3 : in.
//   Instantiated 4x in a generate loop.
//  FSM state encoding: localparams in this file (IDLE, SHIFT, PACK).
// TESTING
//  1. rst for 2 cycles -> big_bin=20'h84200, busy=0, done=0.
//  2. bin_in=1234, blank_en=0, start 1 cycle -> done exactly 15 cycles later; big_bin=20'h08864.
//  3. bin_in=42, blank_en=1 -> big_bin=20'h84082; then bin_in=0, blank_en=1 -> big_bin=20'h84200.
//  4. bin_in=9999 -> 20'h4A529; bin_in=10000 -> 20'h8C631 (dashes); both with 15-cycle latency.
//  5. start pulsed again at cycles 3 and 9 of a conversion -> ignored, a single done;
//     start held high -> done every 16 cycles.
//  6. rst asserted at SHIFT cycle 7 -> no done; big_bin=20'h84200; a following start converts correctly.

Source files
------------

// File: rtl/bin_to_digits_pkg.sv
// Shared constants, state encoding and digit packing for the binary-to-display converter.
// The display codes here must match the ones the seven-segment decoder renders.
package bin_to_digits_pkg;

   localparam int IN_W        = 14;
   localparam int DIG_W       = 5;
   localparam int BCD_W       = 16;
   localparam int CNT_W       = $clog2(IN_W);
   localparam int MAX_DISPLAY = 9999;

   localparam logic [DIG_W-1:0] BLANK_CODE = 5'd16;
   localparam logic [DIG_W-1:0] DASH_CODE  = 5'd17;

   // Power-on display: three blanks and a single zero in the ones position.
   localparam logic [4*DIG_W-1:0] BIG_BIN_RST = {BLANK_CODE, BLANK_CODE, BLANK_CODE, 5'd0};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_PACK  = 2'd2
   } state_t;

   // Turn the finished BCD accumulator into four display codes, d3 in the top bits.
   // Blanking walks down from the thousands digit and stops at the first non-zero
   // digit; the ones digit always shows so a zero value still reads "0".
   function automatic logic [4*DIG_W-1:0] pack_digits(input logic [BCD_W-1:0] bcd,
                                                      input logic             ovf,
                                                      input logic             blank);
      logic [DIG_W-1:0] d3, d2, d1, d0;
      logic             lead3, lead2, lead1;
      d3 = {1'b0, bcd[15:12]};
      d2 = {1'b0, bcd[11:8]};
      d1 = {1'b0, bcd[7:4]};
      d0 = {1'b0, bcd[3:0]};
      lead3 = blank && (bcd[15:12] == 4'd0);
      lead2 = lead3 && (bcd[11:8] == 4'd0);
      lead1 = lead2 && (bcd[7:4] == 4'd0);
      if (ovf) begin
         d3 = DASH_CODE;
         d2 = DASH_CODE;
         d1 = DASH_CODE;
         d0 = DASH_CODE;
      end else begin
         if (lead3) d3 = BLANK_CODE;
         if (lead2) d2 = BLANK_CODE;
         if (lead1) d1 = BLANK_CODE;
      end
      return {d3, d2, d1, d0};
   endfunction

endpackage

// File: rtl/bin_to_digits_add3.sv
// Single BCD correction cell: a nibble of 5 or more gets +3 so the following
// left shift carries correctly into the next decimal digit.
module bcd_add3
   import bin_to_digits_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [3:0] o_nib
);

   // Values 5..9 are the only ones reachable in a valid BCD nibble that need correcting.
   always_comb begin
      o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;
   end

endmodule

// File: rtl/bin_to_digits.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the 4-digit display mux.
// big_bin only changes in the PACK cycle, so the display holds steady during a conversion.
module bin_to_digits
   import bin_to_digits_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_W-1:0]      bin_in,
   input  logic                 start,
   input  logic                 blank_en,
   output logic                 busy,
   output logic                 done,
   output logic [4*DIG_W-1:0]   big_bin
);

   state_t             r_state;
   state_t             w_next;
   logic [IN_W-1:0]    r_shreg;
   logic [BCD_W-1:0]   r_bcd;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ovf;
   logic               r_blank;
   logic               r_done;
   logic [4*DIG_W-1:0] r_big_bin;
   logic [BCD_W-1:0]   w_adj;

   genvar g;
   generate
      for (g = 0; g < BCD_W / 4; g++) begin : g_add3
         bcd_add3 u_add3 (
            .i_nib (r_bcd[4*g +: 4]),
            .o_nib (w_adj[4*g +: 4])
         );
      end
   endgenerate

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic: IN_W shift cycles counted down to zero, then one pack cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_next = ST_SHIFT;
         ST_SHIFT: if (r_cnt == '0) w_next = ST_PACK;
         ST_PACK:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Datapath: capture on accept, correct-then-shift each SHIFT cycle, publish in PACK.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shreg   <= '0;
         r_bcd     <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         r_blank   <= 1'b0;
         r_done    <= 1'b0;
         r_big_bin <= BIG_BIN_RST;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_shreg <= bin_in;
                  r_blank <= blank_en;
                  r_bcd   <= '0;
                  r_cnt   <= CNT_W'(IN_W - 1);
                  r_ovf   <= (bin_in > IN_W'(MAX_DISPLAY));
               end
            end
            ST_SHIFT: begin
               {r_bcd, r_shreg} <= {w_adj[BCD_W-2:0], r_shreg, 1'b0};
               r_cnt            <= r_cnt - CNT_W'(1);
               // A carry out of the top digit only happens for values already
               // flagged as overflow, so folding it in never changes the result.
               r_ovf            <= r_ovf | w_adj[BCD_W-1];
            end
            ST_PACK: begin
               r_big_bin <= pack_digits(r_bcd, r_ovf, r_blank);
               r_done    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy    = (r_state != ST_IDLE);
   assign done    = r_done;
   assign big_bin = r_big_bin;

endmodule
